// File: rtl/midi_voice_alloc.sv
// MIDI note front end: parses a byte-strobe MIDI stream, allocates voices, emits one voice event at a time.
// Latency: 2 cycles from the sampled velocity byte to Ev_valid (parser register, then event register).
// Backpressure: Ev_* hold while Ev_valid & !Ev_ready; an event produced while one is stuck is dropped and sets IO_overflow.
//
// Ports:
//   IO_main_clk, IO_reset             clock, synchronous active-high reset
//   IO_MIDI_valid, IO_MIDI_byte       one-cycle byte strobe and received MIDI byte
//   Ev_valid, Ev_ready                event handshake towards the operator dispatcher
//   Ev_voice, Ev_key_on, Ev_note      target voice, key on/off, MIDI note number
//   Ev_inc                            DDS phase increment for Ev_note
//   IO_overflow                       sticky: an event was dropped
module midi_voice_alloc #(
    parameter int ACC_RES      = 22,
    parameter int VOICE_COUNT  = 2,
    parameter int MIDI_CHANNEL = 0
) (
    input  logic               IO_main_clk,
    input  logic               IO_reset,
    input  logic               IO_MIDI_valid,
    input  logic [7:0]         IO_MIDI_byte,
    output logic               Ev_valid,
    input  logic               Ev_ready,
    output logic [4:0]         Ev_voice,
    output logic               Ev_key_on,
    output logic [6:0]         Ev_note,
    output logic [ACC_RES-1:0] Ev_inc,
    output logic               IO_overflow
);
    localparam int         PW   = (VOICE_COUNT > 1) ? $clog2(VOICE_COUNT) : 1;
    localparam logic [3:0] CHAN = 4'(MIDI_CHANNEL);
    localparam bit         OMNI = (MIDI_CHANNEL >= 16);

    typedef enum logic [1:0] {WAIT_STATUS, NOTE_D1, NOTE_D2, SKIP} parse_t;

    parse_t     state_q, state_d;
    logic       note_ld, stat_ld, msg_fire;
    logic       stat_on_q;              // latched running status is 0x9n
    logic [6:0] note_q;

    // Completed message, one cycle after the velocity byte
    logic       msg_vld_q, msg_on_q;
    logic [6:0] msg_note_q;

    // Voice table
    logic [VOICE_COUNT-1:0] v_act;
    logic [6:0]             v_note [VOICE_COUNT];
    logic [PW-1:0]          steal_q;

    logic is_note_status, chan_ok;
    assign is_note_status = (IO_MIDI_byte[7:5] == 3'b100);
    assign chan_ok        = OMNI || (IO_MIDI_byte[3:0] == CHAN);

    // ---------------- Parser ----------------
    always_ff @(posedge IO_main_clk) begin
        if (IO_reset) begin
            state_q    <= WAIT_STATUS;
            stat_on_q  <= 1'b0;
            note_q     <= '0;
            msg_vld_q  <= 1'b0;
            msg_on_q   <= 1'b0;
            msg_note_q <= '0;
        end else begin
            state_q   <= state_d;
            msg_vld_q <= msg_fire;
            if (stat_ld) stat_on_q <= IO_MIDI_byte[4];
            if (note_ld) note_q <= IO_MIDI_byte[6:0];
            if (msg_fire) begin
                // 0x9n with velocity 0 is a note-off
                msg_on_q   <= stat_on_q && (IO_MIDI_byte[6:0] != 7'd0);
                msg_note_q <= note_q;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        note_ld  = 1'b0;
        stat_ld  = 1'b0;
        msg_fire = 1'b0;
        if (IO_MIDI_valid) begin
            if (IO_MIDI_byte[7]) begin
                if (IO_MIDI_byte[7:3] == 5'b11111) begin
                    // realtime bytes pass through without touching the parser
                    state_d = state_q;
                end else if (IO_MIDI_byte[7:4] == 4'hF) begin
                    state_d = WAIT_STATUS;
                end else if (is_note_status && chan_ok) begin
                    state_d = NOTE_D1;
                    stat_ld = 1'b1;
                end else begin
                    state_d = SKIP;
                end
            end else begin
                case (state_q)
                    NOTE_D1: begin
                        note_ld = 1'b1;
                        state_d = NOTE_D2;
                    end
                    NOTE_D2: begin
                        msg_fire = 1'b1;
                        state_d  = NOTE_D1;
                    end
                    default: state_d = state_q;
                endcase
            end
        end
    end

    // ---------------- Voice selection ----------------
    logic          hit, free, steal;
    logic [PW-1:0] hit_idx, free_idx, sel_idx;

    // Descending scan so the lowest matching index is the last one written.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free     = 1'b0;
        free_idx = '0;
        for (int i = VOICE_COUNT - 1; i >= 0; i--) begin
            if (v_act[i] && (v_note[i] == msg_note_q)) begin
                hit     = 1'b1;
                hit_idx = PW'(i);
            end
            if (!v_act[i]) begin
                free     = 1'b1;
                free_idx = PW'(i);
            end
        end
    end

    always_comb begin
        steal   = 1'b0;
        sel_idx = hit_idx;
        if (msg_on_q && !hit) begin
            if (free) begin
                sel_idx = free_idx;
            end else begin
                sel_idx = steal_q;
                steal   = 1'b1;
            end
        end
    end

    // ---------------- Increment ----------------
    function automatic logic [ACC_RES-1:0] top_inc(input logic [3:0] k);
        case (k)
            4'd0:    top_inc = ACC_RES'(731558);
            4'd1:    top_inc = ACC_RES'(775059);
            4'd2:    top_inc = ACC_RES'(821146);
            4'd3:    top_inc = ACC_RES'(869974);
            4'd4:    top_inc = ACC_RES'(921705);
            4'd5:    top_inc = ACC_RES'(976513);
            4'd6:    top_inc = ACC_RES'(1034579);
            4'd7:    top_inc = ACC_RES'(1096098);
            4'd8:    top_inc = ACC_RES'(1161276);
            4'd9:    top_inc = ACC_RES'(1230329);
            4'd10:   top_inc = ACC_RES'(1303488);
            4'd11:   top_inc = ACC_RES'(1380998);
            default: top_inc = '0;
        endcase
    endfunction

    logic [3:0]         oct, semi;
    logic [ACC_RES-1:0] inc_calc;
    assign oct      = 4'(msg_note_q / 7'd12);
    assign semi     = 4'(msg_note_q % 7'd12);
    // table holds octave 10 (C9..B9); note 127 is octave 10, so the shift never goes negative
    assign inc_calc = top_inc(semi) >> (4'd10 - oct);

    // ---------------- Event register ----------------
    logic ev_new, ev_load;
    assign ev_new  = msg_vld_q && (msg_on_q || hit);
    assign ev_load = ev_new && (!Ev_valid || Ev_ready);

    always_ff @(posedge IO_main_clk) begin
        if (IO_reset) begin
            Ev_valid    <= 1'b0;
            Ev_voice    <= '0;
            Ev_key_on   <= 1'b0;
            Ev_note     <= '0;
            Ev_inc      <= '0;
            IO_overflow <= 1'b0;
            v_act       <= '0;
            steal_q     <= '0;
            for (int i = 0; i < VOICE_COUNT; i++) v_note[i] <= '0;
        end else begin
            if (ev_load) begin
                Ev_valid  <= 1'b1;
                Ev_voice  <= 5'(sel_idx);
                Ev_key_on <= msg_on_q;
                Ev_note   <= msg_note_q;
                Ev_inc    <= inc_calc;
                if (msg_on_q) begin
                    v_act[sel_idx]  <= 1'b1;
                    v_note[sel_idx] <= msg_note_q;
                    if (steal)
                        steal_q <= (steal_q == PW'(VOICE_COUNT - 1)) ? '0 : steal_q + PW'(1);
                end else begin
                    v_act[sel_idx] <= 1'b0;
                end
            end else if (Ev_ready) begin
                Ev_valid <= 1'b0;
            end
            // dropped event: table and steal pointer are left untouched above
            if (ev_new && !ev_load) IO_overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_midi_voice_alloc.sv
module tb_midi_voice_alloc;
    localparam int VC = 2;

    logic        clk = 1'b0;
    logic        rst, mv, ev_ready;
    logic [7:0]  mb;
    logic        ev_valid, ev_key_on, ovf;
    logic [4:0]  ev_voice;
    logic [6:0]  ev_note;
    logic [21:0] ev_inc;

    always #5 clk = ~clk;

    midi_voice_alloc #(.ACC_RES(22), .VOICE_COUNT(VC), .MIDI_CHANNEL(0)) dut (
        .IO_main_clk  (clk),
        .IO_reset     (rst),
        .IO_MIDI_valid(mv),
        .IO_MIDI_byte (mb),
        .Ev_valid     (ev_valid),
        .Ev_ready     (ev_ready),
        .Ev_voice     (ev_voice),
        .Ev_key_on    (ev_key_on),
        .Ev_note      (ev_note),
        .Ev_inc       (ev_inc),
        .IO_overflow  (ovf)
    );

    typedef struct packed {
        logic [4:0]  voice;
        logic        on;
        logic [6:0]  note;
        logic [21:0] inc;
    } ev_t;

    ev_t exp_q[$];
    ev_t got_q[$];
    int  pass_cnt = 0;
    int  total_cnt = 0;

    // Behavioural voice-table model
    bit m_act [VC];
    int m_note[VC];
    int m_ptr;
    bit m_ovf;
    int top_tab[12] = '{731558, 775059, 821146, 869974, 921705, 976513,
                        1034579, 1096098, 1161276, 1230329, 1303488, 1380998};

    task automatic chk(input string name, input longint act, input longint exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic int inc_of(input int n);
        return top_tab[n % 12] >> (10 - n / 12);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < VC; i++) begin
            m_act[i]  = 1'b0;
            m_note[i] = 0;
        end
        m_ptr = 0;
        m_ovf = 1'b0;
        exp_q.delete();
        got_q.delete();
    endtask

    // Apply one completed note message to the model
    task automatic exp_msg(input bit on, input int note);
        int  v = -1;
        bit  stole = 1'b0;
        ev_t e;
        for (int i = 0; i < VC; i++)
            if (v < 0 && m_act[i] && m_note[i] == note) v = i;
        if (on) begin
            for (int i = 0; i < VC; i++)
                if (v < 0 && !m_act[i]) v = i;
            if (v < 0) begin
                v = m_ptr;
                stole = 1'b1;
            end
        end
        if (v >= 0) begin
            if (exp_q.size() != 0) begin
                m_ovf = 1'b1;
            end else begin
                if (on) begin
                    m_act[v]  = 1'b1;
                    m_note[v] = note;
                    if (stole) m_ptr = (m_ptr + 1) % VC;
                end else begin
                    m_act[v] = 1'b0;
                end
                e.voice = 5'(v);
                e.on    = on;
                e.note  = 7'(note);
                e.inc   = 22'(inc_of(note));
                exp_q.push_back(e);
            end
        end
    endtask

    // Compare process: every pending event must be the model's next event
    always @(negedge clk) begin
        if (!rst && ev_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_event", ev_valid, 0);
            end else begin
                chk("event", {ev_voice, ev_key_on, ev_note, ev_inc}, exp_q[0]);
                if (ev_ready) begin
                    got_q.push_back({ev_voice, ev_key_on, ev_note, ev_inc});
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        mv = 1'b1;
        mb = b;
        tick();
        mv = 1'b0;
        tick();
        tick();
    endtask

    task automatic send_last(input logic [7:0] b, input bit on, input int note);
        exp_msg(on, note);
        send_byte(b);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        tick();
        tick();
        chk("reset_outputs", {ev_valid, ev_voice, ev_key_on, ev_note, ev_inc, ovf}, 0);
        rst = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        repeat (4) tick();
        while ((exp_q.size() != 0 || ev_valid) && n < 50) begin
            tick();
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
        chk("overflow_flag", ovf, m_ovf);
    endtask

    task automatic chk_got(input string name, input int i, input ev_t e);
        if (i >= got_q.size()) chk(name, got_q.size(), i + 1);
        else chk(name, got_q[i], e);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        mv = 1'b0;
        mb = 8'h00;
        ev_ready = 1'b1;

        // Basic note-on with exact latency
        do_reset();
        send_byte(8'h90);
        send_byte(8'h45);
        exp_msg(1'b1, 69);
        mv = 1'b1;
        mb = 8'h64;
        @(negedge clk);
        chk("lat_c0_valid", ev_valid, 0);
        tick();
        mv = 1'b0;
        @(negedge clk);
        chk("lat_c1_valid", ev_valid, 0);
        tick();
        @(negedge clk);
        chk("lat_c2_valid", ev_valid, 1);
        chk("lat_c2_event", {ev_voice, ev_key_on, ev_note, ev_inc}, {5'd0, 1'b1, 7'd69, 22'd38447});
        tick();
        @(negedge clk);
        chk("lat_c3_valid", ev_valid, 0);
        drain();

        // Running status
        do_reset();
        send_byte(8'h90); send_byte(8'h3C); send_last(8'h40, 1'b1, 60);
        send_byte(8'h40); send_last(8'h40, 1'b1, 64);
        send_byte(8'h3C); send_last(8'h00, 1'b0, 60);
        drain();
        chk("rs_count", got_q.size(), 3);
        chk_got("rs_ev0", 0, {5'd0, 1'b1, 7'd60, 22'd22861});
        chk_got("rs_ev1", 1, {5'd1, 1'b1, 7'd64, 22'd28803});
        chk_got("rs_ev2", 2, {5'd0, 1'b0, 7'd60, 22'd22861});

        // Voice stealing
        do_reset();
        send_byte(8'h90);
        send_byte(8'h0A); send_last(8'h40, 1'b1, 10);
        send_byte(8'h14); send_last(8'h40, 1'b1, 20);
        send_byte(8'h1E); send_last(8'h40, 1'b1, 30);
        send_byte(8'h28); send_last(8'h40, 1'b1, 40);
        send_byte(8'h0A); send_last(8'h00, 1'b0, 10);
        drain();
        chk("steal_count", got_q.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < got_q.size()) chk("steal_voice", got_q[i].voice, i % 2);

        // Channel, realtime and non-note filtering; increment extremes
        do_reset();
        send_byte(8'h91); send_byte(8'h30); send_byte(8'h40);
        send_byte(8'h90); send_byte(8'h30); send_byte(8'hF8); send_last(8'h40, 1'b1, 48);
        send_byte(8'hB0); send_byte(8'h07); send_byte(8'h7F);
        send_byte(8'h90); send_byte(8'h00); send_last(8'h40, 1'b1, 0);
        send_byte(8'h7F); send_last(8'h40, 1'b1, 127);
        drain();
        chk("filt_count", got_q.size(), 3);
        chk_got("filt_note48", 0, {5'd0, 1'b1, 7'd48, 22'd11430});
        chk_got("filt_note0", 1, {5'd1, 1'b1, 7'd0, 22'd714});
        chk_got("filt_note127", 2, {5'd0, 1'b1, 7'd127, 22'd1096098});

        // Backpressure and overflow
        do_reset();
        ev_ready = 1'b0;
        send_byte(8'h90); send_byte(8'h3C); send_last(8'h40, 1'b1, 60);
        send_byte(8'h3E); send_last(8'h40, 1'b1, 62);
        repeat (3) tick();
        @(negedge clk);
        chk("bp_valid_held", ev_valid, 1);
        chk("bp_note_held", ev_note, 60);
        chk("bp_overflow", ovf, 1);
        chk("bp_no_transfer", got_q.size(), 0);
        tick();
        ev_ready = 1'b1;
        drain();
        chk("bp_single_transfer", got_q.size(), 1);
        send_byte(8'h3E); send_last(8'h00, 1'b0, 62);
        drain();
        chk("bp_dropped_not_in_table", got_q.size(), 1);

        // Reset in the middle of a message
        do_reset();
        send_byte(8'h90);
        send_byte(8'h45);
        rst = 1'b1;
        model_reset();
        tick();
        rst = 1'b0;
        send_byte(8'h64);
        drain();
        chk("midrst_outputs", {ev_valid, ev_voice, ev_key_on, ev_note, ev_inc, ovf}, 0);
        chk("midrst_no_event", got_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
